// File: rtl/buffer_ctrl_pkg.sv
// Shared definitions for the circular-buffer sequencing controller.
// Holds the default burst geometry, the controller state encoding and the
// registered control-flag bundle with its per-state decode.
package buffer_ctrl_pkg;

   // Default burst geometry; 2**CW_DEF must cover max(K_DEF, J_DEF).
   localparam int unsigned K_DEF  = 4;
   localparam int unsigned J_DEF  = 4;
   localparam int unsigned CW_DEF = 2;

   localparam int unsigned ST_W = 3;

   // State encoding shared with the datapath and the bench.
   typedef enum logic [ST_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_WCOMMIT = 3'd2,
      ST_READ    = 3'd3,
      ST_RCOMMIT = 3'd4
   } state_t;

   // Moore control flags, registered alongside the state.
   typedef struct packed {
      logic in_ready;
      logic out_valid;
      logic ld_wptr;
      logic ld_rptr;
      logic busy;
   } ctrl_t;

   // Control flags presented while the controller sits in state s.
   function automatic ctrl_t ctrl_of(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_WRITE: begin
            c.in_ready = 1'b1;
            c.busy     = 1'b1;
         end
         ST_WCOMMIT: begin
            c.ld_wptr = 1'b1;
            c.busy    = 1'b1;
         end
         ST_READ: begin
            c.out_valid = 1'b1;
            c.busy      = 1'b1;
         end
         ST_RCOMMIT: begin
            c.ld_rptr = 1'b1;
            c.busy    = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/buffer_ctrl_burst_counter.sv
// Per-beat offset counter for one burst.
// Ports: clk, rst (async, active-high); inc advances on an accepted beat,
// clr forces zero; term is the offset of the final beat; cnt is the current
// offset and last flags cnt == term.
module buffer_ctrl_burst_counter #(
   parameter int unsigned CW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          clr,
   input  logic [CW-1:0] term,
   output logic [CW-1:0] cnt,
   output logic          last
);

   assign last = (cnt == term);

   // The final beat returns the counter to zero so it never exceeds term.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= last ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/buffer_ctrl.sv
// Sequencing controller for the circular-buffer datapath.
// Arbitrates producer K-word write bursts against consumer J-word read bursts,
// alternating when both are ready, and drives the beat offset, RAM write
// strobe and one-cycle pointer-load strobes.
// Ports: clk, rst (async, active-high); in_valid/in_ready producer handshake
// (in_valid doubles as the write request); out_req read request;
// out_valid/out_ready consumer handshake; full/empty datapath flags sampled
// only in IDLE; wr_en RAM write strobe; cnt beat offset; ld_wptr/ld_rptr
// pointer-load strobes; busy high outside IDLE.
module buffer_ctrl
   import buffer_ctrl_pkg::*;
#(
   parameter int unsigned K  = K_DEF,
   parameter int unsigned J  = J_DEF,
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          out_req,
   output logic          out_valid,
   input  logic          out_ready,
   input  logic          full,
   input  logic          empty,
   output logic          wr_en,
   output logic [CW-1:0] cnt,
   output logic          ld_wptr,
   output logic          ld_rptr,
   output logic          busy
);

   state_t        state;
   ctrl_t         ctrl;
   logic          last_w;

   logic          w_ok_c;
   logic          r_ok_c;
   logic          beat_w_c;
   logic          beat_r_c;
   logic          commit_c;
   logic          last_c;
   logic [CW-1:0] term_c;

   // Request qualification; flags only matter when starting a burst.
   assign w_ok_c = in_valid && !full;
   assign r_ok_c = out_req && !empty;

   // Accepted beats in the active burst.
   assign beat_w_c = (state == ST_WRITE) && in_valid;
   assign beat_r_c = (state == ST_READ) && out_ready;
   assign commit_c = (state == ST_WCOMMIT) || (state == ST_RCOMMIT);
   assign term_c   = (state == ST_READ) ? CW'(J - 1) : CW'(K - 1);

   buffer_ctrl_burst_counter #(
      .CW(CW)
   ) u_burst_counter (
      .clk (clk),
      .rst (rst),
      .inc (beat_w_c || beat_r_c),
      .clr (commit_c),
      .term(term_c),
      .cnt (cnt),
      .last(last_c)
   );

   // Burst sequencer; control flags are registered with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         ctrl   <= '0;
         last_w <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // On contention the side not served last wins.
               if (w_ok_c && (!r_ok_c || !last_w)) begin
                  state <= ST_WRITE;
                  ctrl  <= ctrl_of(ST_WRITE);
               end else if (r_ok_c) begin
                  state <= ST_READ;
                  ctrl  <= ctrl_of(ST_READ);
               end
            end
            ST_WRITE: begin
               if (beat_w_c && last_c) begin
                  state <= ST_WCOMMIT;
                  ctrl  <= ctrl_of(ST_WCOMMIT);
               end
            end
            ST_WCOMMIT: begin
               state  <= ST_IDLE;
               ctrl   <= ctrl_of(ST_IDLE);
               last_w <= 1'b1;
            end
            ST_READ: begin
               if (beat_r_c && last_c) begin
                  state <= ST_RCOMMIT;
                  ctrl  <= ctrl_of(ST_RCOMMIT);
               end
            end
            ST_RCOMMIT: begin
               state  <= ST_IDLE;
               ctrl   <= ctrl_of(ST_IDLE);
               last_w <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               ctrl  <= '0;
            end
         endcase
      end
   end

   assign in_ready  = ctrl.in_ready;
   assign out_valid = ctrl.out_valid;
   assign ld_wptr   = ctrl.ld_wptr;
   assign ld_rptr   = ctrl.ld_rptr;
   assign busy      = ctrl.busy;
   assign wr_en     = beat_w_c;

endmodule

// File: tb/tb_buffer_ctrl.sv
// Scoreboard bench for buffer_ctrl: stimulus pushes the expected beat/commit
// sequence of each requested burst set; a monitor pops and compares on every
// observed DUT event.
module tb_buffer_ctrl;

   localparam int K  = 4;
   localparam int J  = 4;
   localparam int CW = 2;

   localparam int EV_WB = 0;
   localparam int EV_RB = 1;
   localparam int EV_LW = 2;
   localparam int EV_LR = 3;

   typedef struct {
      int kind;
      int cnt;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          out_req = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          full = 1'b0;
   logic          empty = 1'b0;
   logic          wr_en;
   logic [CW-1:0] cnt;
   logic          ld_wptr;
   logic          ld_rptr;
   logic          busy;

   int  n_checks = 0;
   int  n_fail   = 0;
   ev_t exp_q[$];

   int  w_pend   = 0;
   int  r_pend   = 0;
   bit  blk_w    = 1'b0;
   bit  blk_r    = 1'b0;
   bit  stall_en = 1'b0;
   bit  pat_en   = 1'b0;
   int  pidx     = 0;
   bit  pat[6];
   bit  m_last_w = 1'b0;

   buffer_ctrl #(.K(K), .J(J), .CW(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_req  (out_req),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .full     (full),
      .empty    (empty),
      .wr_en    (wr_en),
      .cnt      (cnt),
      .ld_wptr  (ld_wptr),
      .ld_rptr  (ld_rptr),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input int act, input int exp);
      n_checks = n_checks + 1;
      if (act != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference arbitration: alternate on contention, otherwise serve whoever asks.
   function automatic void issue(input int nw, input int nr);
      int  pw;
      int  pr;
      ev_t e;
      pw = nw;
      pr = nr;
      while (pw > 0 || pr > 0) begin
         if (pw > 0 && (pr == 0 || !m_last_w)) begin
            for (int i = 0; i < K; i++) begin
               e.kind = EV_WB; e.cnt = i; exp_q.push_back(e);
            end
            e.kind = EV_LW; e.cnt = 0; exp_q.push_back(e);
            pw = pw - 1;
            m_last_w = 1'b1;
         end else begin
            for (int i = 0; i < J; i++) begin
               e.kind = EV_RB; e.cnt = i; exp_q.push_back(e);
            end
            e.kind = EV_LR; e.cnt = 0; exp_q.push_back(e);
            pr = pr - 1;
            m_last_w = 1'b0;
         end
      end
      w_pend = w_pend + nw;
      r_pend = r_pend + nr;
   endfunction

   // One cycle of reactive stimulus, driven 2 time units after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
      if (ld_wptr && w_pend > 0) w_pend = w_pend - 1;
      if (ld_rptr && r_pend > 0) r_pend = r_pend - 1;
      if (w_pend > 0) begin
         if (in_ready && stall_en) in_valid = ($urandom_range(3) != 0);
         else in_valid = 1'b1;
      end else begin
         in_valid = blk_w;
      end
      out_req = (r_pend > 0) || blk_r;
      if (pat_en && out_valid) begin
         out_ready = (pidx < 6) ? pat[pidx] : 1'b1;
         pidx = pidx + 1;
      end else begin
         out_ready = stall_en ? ($urandom_range(2) != 0) : 1'b1;
      end
      // Flags are don't-care inside a burst, so scramble them there.
      if (in_ready || out_valid) begin
         full  = ($urandom_range(1) != 0);
         empty = ($urandom_range(1) != 0);
      end else begin
         full  = blk_w;
         empty = blk_r;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"},     int'(wr_en),     0);
      check({tag, "_in_ready"},  int'(in_ready),  0);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_ld_wptr"},   int'(ld_wptr),   0);
      check({tag, "_ld_rptr"},   int'(ld_rptr),   0);
      check({tag, "_busy"},      int'(busy),      0);
      check({tag, "_cnt"},       int'(cnt),       0);
   endtask

   task automatic apply_reset(input string tag);
      rst = 1'b1;
      #1;
      check_all_zero(tag);
      exp_q.delete();
      w_pend = 0; r_pend = 0; m_last_w = 1'b0;
      in_valid = 1'b0; out_req = 1'b0; full = 1'b0; empty = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check_all_zero({tag, "_first_idle"});
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while ((w_pend != 0 || r_pend != 0 || busy) && n < budget) begin
         step();
         n = n + 1;
      end
      check({tag, "_done_in_budget"}, int'(n < budget), 1);
      @(negedge clk);
      #1;
      check({tag, "_queue_drained"}, exp_q.size(), 0);
   endtask

   // Monitor: per-cycle invariants plus in-order event scoreboard.
   initial begin
      ev_t e;
      int  kind;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("ld_exclusive", int'(ld_wptr && ld_rptr), 0);
            check("busy_outside_idle", int'(busy), int'(in_ready | out_valid | ld_wptr | ld_rptr));
            check("wr_en_only_in_write", int'(wr_en && !in_ready), 0);
            if (!busy) check("cnt_zero_in_idle", int'(cnt), 0);
            kind = -1;
            if (wr_en) kind = EV_WB;
            else if (out_valid && out_ready) kind = EV_RB;
            else if (ld_wptr) kind = EV_LW;
            else if (ld_rptr) kind = EV_LR;
            if (kind >= 0) begin
               n_checks = n_checks + 1;
               if (exp_q.size() == 0) begin
                  n_fail = n_fail + 1;
                  $display("FAIL event: got kind=%0d cnt=%0d, expected none (t=%0t)", kind, cnt, $time);
               end else begin
                  e = exp_q.pop_front();
                  if (e.kind != kind || ((kind == EV_WB || kind == EV_RB) && e.cnt != int'(cnt))) begin
                     n_fail = n_fail + 1;
                     $display("FAIL event: got kind=%0d cnt=%0d, expected kind=%0d cnt=%0d (t=%0t)",
                              kind, cnt, e.kind, e.cnt, $time);
                  end
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  ov;
      int  beats;
      int  lds;
      bit  found;
      bit  exp_b;
      int  exp_cnt;

      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
      pat[3] = 1'b0; pat[4] = 1'b1; pat[5] = 1'b1;

      // Power-on reset
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset_hold");
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check_all_zero("first_idle");

      // Unstalled write burst, cycle-exact
      stall_en = 1'b0;
      issue(1, 0);
      for (int c = 1; c <= K + 3; c++) begin
         step();
         @(negedge clk);
         exp_b   = (c >= 2 && c <= K + 1);
         exp_cnt = exp_b ? c - 2 : 0;
         check($sformatf("wburst_c%0d_in_ready", c), int'(in_ready), int'(exp_b));
         check($sformatf("wburst_c%0d_wr_en", c),    int'(wr_en),    int'(exp_b));
         check($sformatf("wburst_c%0d_cnt", c),      int'(cnt),      exp_cnt);
         check($sformatf("wburst_c%0d_ld_wptr", c),  int'(ld_wptr),  int'(c == K + 2));
         check($sformatf("wburst_c%0d_busy", c),     int'(busy),     int'(c >= 2 && c <= K + 2));
      end
      wait_done("wburst", 20);

      // Read burst with out_ready pattern 1,0,1,0,1,1
      pat_en = 1'b1;
      pidx = 0;
      issue(0, 1);
      ov = 0; beats = 0; lds = 0;
      for (int n = 0; n < 40 && (r_pend != 0 || busy); n++) begin
         step();
         @(negedge clk);
         ov    = ov + int'(out_valid);
         beats = beats + int'(out_valid && out_ready);
         lds   = lds + int'(ld_rptr);
      end
      pat_en = 1'b0;
      check("rburst_out_valid_cycles", ov, 6);
      check("rburst_beats", beats, J);
      check("rburst_ld_rptr_count", lds, 1);
      wait_done("rburst", 20);

      // Blocking flags
      blk_w = 1'b1;
      for (int n = 0; n < 6; n++) begin
         step();
         @(negedge clk);
         check("full_blocks_in_ready", int'(in_ready), 0);
         check("full_blocks_busy", int'(busy), 0);
      end
      blk_w = 1'b0;
      blk_r = 1'b1;
      for (int n = 0; n < 6; n++) begin
         step();
         @(negedge clk);
         check("empty_blocks_out_valid", int'(out_valid), 0);
         check("empty_blocks_busy", int'(busy), 0);
      end
      blk_r = 1'b0;
      step();

      // Reset in the middle of a read burst
      stall_en = 1'b1;
      issue(0, 1);
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         step();
         found = out_valid;
      end
      check("mid_read_reached", int'(found), 1);
      apply_reset("reset_mid_read");

      // Contention straight after reset: write, read, write
      issue(2, 1);
      wait_done("alternate", 400);

      // Reset during write beat 2, then a clean burst
      stall_en = 1'b0;
      issue(1, 0);
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         step();
         found = in_ready && (cnt == CW'(1));
      end
      check("mid_write_reached", int'(found), 1);
      apply_reset("reset_mid_write");
      issue(1, 0);
      wait_done("after_reset_write", 40);

      // Randomized burst mixes with stalls and scrambled flags
      stall_en = 1'b1;
      for (int it = 0; it < 25; it++) begin
         issue(int'($urandom_range(2)), int'($urandom_range(2)));
         wait_done($sformatf("rand%0d", it), 400);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
